// File: rtl/prog_loader.sv
// Boot loader: assembles a valid/ready byte stream into instruction words, writes them to
// instruction memory, then releases the CPU with a one-cycle start pulse.
// Optional byte-XOR checksum stage: define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int INSTR_W = 19,
  parameter int ADDR_W  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               start,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int NB    = (INSTR_W + 7) / 8;
  localparam int BC_W  = $clog2(NB + 1);
  localparam int IDX_W = ADDR_W + 1;
  // Common width for comparing the 16-bit length against the word index.
  localparam int CMP_W = (IDX_W > 16) ? IDX_W : 16;
  localparam logic [CMP_W-1:0] MAX_N = CMP_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_START = 3'd4,
    S_DONE  = 3'd5,
`ifdef PROG_LOADER_CHECKSUM_EN
    S_CHK   = 3'd7,
`endif
    S_ERR   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [BC_W-1:0]     byte_cnt_q, byte_cnt_d;
  logic [15:0]         len_q, len_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NB*8-1:0]     asm_q, asm_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [INSTR_W-1:0]  wdata_q, wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]          xor_q, xor_d;
`endif

  logic        xfer;
  logic [15:0] len_new;

  assign in_ready = (state_q == S_LEN) || (state_q == S_DATA)
`ifdef PROG_LOADER_CHECKSUM_EN
                    || (state_q == S_CHK)
`endif
                    ;
  assign xfer       = in_valid & in_ready;
  assign len_new    = {len_q[15:8], in_data};
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      asm_q      <= asm_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q      <= xor_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    idx_d      = idx_q;
    asm_d      = asm_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    xor_d      = xor_q;
`endif
    imem_we  = 1'b0;
    cpu_hold = 1'b0;
    start    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        done     = (state_q == S_DONE);
        err      = (state_q == S_ERR);
        cpu_hold = (state_q == S_ERR);
        if (load) begin
          state_d    = S_LEN;
          byte_cnt_d = '0;
          len_d      = '0;
          idx_d      = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d      = '0;
`endif
        end
      end

      S_LEN: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) begin
          if (byte_cnt_q == '0) begin
            len_d[15:8] = in_data;
            byte_cnt_d  = BC_W'(1);
          end else begin
            len_d      = len_new;
            byte_cnt_d = '0;
            if ((len_new == 16'd0) || (CMP_W'(len_new) > MAX_N))
              state_d = S_ERR;
            else
              state_d = S_DATA;
          end
        end
      end

      S_DATA: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (xfer) begin
          // Little-endian: byte k of the word lands at bits [8k+7:8k].
          for (int i = 0; i < NB; i++) begin
            if (byte_cnt_q == BC_W'(i))
              asm_d[i*8 +: 8] = in_data;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          xor_d = xor_q ^ in_data;
`endif
          if (byte_cnt_q == BC_W'(NB - 1)) begin
            byte_cnt_d = '0;
            state_d    = S_WRITE;
            wdata_d    = asm_d[INSTR_W-1:0];
            addr_d     = idx_q[ADDR_W-1:0];
          end else begin
            byte_cnt_d = byte_cnt_q + BC_W'(1);
          end
        end
      end

      S_WRITE: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        imem_we  = 1'b1;
        idx_d    = idx_q + IDX_W'(1);
        if (CMP_W'(idx_d) == CMP_W'(len_q)) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_START;
`endif
        end else begin
          state_d = S_DATA;
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      S_CHK: begin
        busy     = 1'b1;
        cpu_hold = 1'b1;
        if (xfer)
          state_d = (in_data == xor_q) ? S_START : S_ERR;
      end
`endif

      S_START: begin
        busy    = 1'b1;
        start   = 1'b1;
        state_d = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream boot stage for the single-cycle CPU.
- Accepts a byte stream over a valid/ready handshake and assembles the bytes into instruction words.
- Writes each word into instruction memory through a dedicated write port.
- After the last word is written, holds the CPU off and pulses the CPU's start input for exactly one cycle.

Parameters:
INSTR_W, 19, instruction width in bits; NB = (INSTR_W+7)/8 bytes per word (3 at default)
ADDR_W, 12, instruction memory address width; capacity 2^ADDR_W words

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (0 = reset)
load  input  1  begin a load session; sampled only in IDLE, DONE or ERR
in_data  input  8  stream byte
in_valid  input  1  byte present
in_ready  output  1  loader accepts byte this cycle
imem_we  output  1  instruction memory write strobe
imem_addr  output  ADDR_W  write address
imem_wdata  output  INSTR_W  write data
cpu_hold  output  1  high while loading; CPU must ignore start/fetch
start  output  1  one-cycle start pulse to cpu
busy  output  1  session in progress
done  output  1  load completed OK; sticky
err  output  1  load failed; sticky

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; word counter, byte counter and length register cleared.
- A byte transfers when in_valid & in_ready are both high at a clk edge.
- in_ready=1 only in states LEN, DATA, CHK.
- States and transitions:
  - IDLE/DONE/ERR: load=1 -> LEN; clears done, err, counters; cpu_hold=1; busy=1.
  - LEN: takes 2 bytes, big-endian, as the 16-bit word count N.
    - After the 2nd byte: N==0 or N>2^ADDR_W -> ERR; otherwise -> DATA.
  - DATA: takes NB bytes, little-endian, into an assembly register.
    - Bits at or above INSTR_W are discarded.
    - After the NB-th byte -> WRITE.
  - WRITE: exactly one cycle.
    - imem_we=1, imem_addr = word index (starts at 0), imem_wdata = assembled word.
    - Word index increments.
    - Index==N after increment -> START (or CHK, see optional feature); otherwise -> DATA.
  - START: start=1 for this one cycle only; cpu_hold=0 in this cycle; -> DONE.
  - DONE: done=1, busy=0, cpu_hold=0; holds until the next load.
  - ERR: err=1, busy=0, cpu_hold=1 (CPU stays held); start never asserted; holds until the next load.
- Latency:
  - imem_we rises in the cycle after the last byte of a word is accepted.
  - start rises in the cycle after the final WRITE cycle (no CHK).
- Stalls: in_valid low stalls the FSM indefinitely with state held; there is no timeout.
- load while busy (LEN/DATA/WRITE/CHK/START) is ignored.
- Reset mid-session: immediate return to IDLE. Memory already written is not rolled back, and start is not issued.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- Word index is ADDR_W+1 bits wide so that N = 2^ADDR_W is reachable without wrap.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - Adds state CHK after the last WRITE. CHK takes one byte.
  - A running XOR is kept over every data byte accepted in DATA; length bytes are excluded.
  - CHK byte equal to the running XOR -> START; unequal -> ERR.
  - The running XOR is cleared on load.
- Not defined:
  - No CHK state and no checksum register; the last WRITE goes directly to START.

Test Plan:
- Two-word load: after reset, load=1, stream 00 02 34 12 05 FF FF 07 with in_valid held high -> imem writes addr0=19'h51234 then addr1=19'h7FFFF, one cycle each; start high exactly 1 cycle, in the cycle after the 2nd write; then done=1, err=0, cpu_hold=0.
- Backpressure/gaps: same stream with in_valid low for 3 cycles between every byte -> identical writes and single start pulse; no extra imem_we; in_ready=0 during WRITE.
- Bad lengths: stream 00 00 -> err=1, start never asserted, cpu_hold=1. Stream 10 01 (N=4097, ADDR_W=12) -> err=1 immediately after the 2nd byte; no imem_we.
- Reset and load-while-busy: pulse rst=0 after byte 5 of the two-word stream -> all outputs 0 asynchronously, state IDLE. Subsequent full load works from addr0. load pulsed mid-DATA is ignored.
- Checksum (macro defined): stream 00 01 34 12 05 23 -> write addr0=19'h51234, start pulse, done=1. Same stream ending in 24 -> write occurs, err=1, no start.
- Reload: after done=1, a second load of 00 01 AA 00 00 -> done clears on load, write addr0=19'h000AA, a fresh start pulse, done=1 again.
